// File: rtl/cdc_pkg.sv
// Shared types and limits for the cdc_bus_rx destination-side synchroniser.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACK     = 2'd2
    } state_t;

    localparam int CDC_SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_bus_rx_if.sv
// Req/ack bus from the source domain plus the downstream valid/ready port.
// master = the source/downstream side, slave = the cdc_bus_rx receiver.
interface cdc_bus_rx_if #(
    parameter int WIDTH = 8
);
    logic             src_req;
    logic [WIDTH-1:0] src_data;
    logic             dst_ack;
    logic             dst_valid;
    logic [WIDTH-1:0] dst_data;
    logic             dst_ready;

    modport master (
        output src_req,
        output src_data,
        output dst_ready,
        input  dst_ack,
        input  dst_valid,
        input  dst_data
    );

    modport slave (
        input  src_req,
        input  src_data,
        input  dst_ready,
        output dst_ack,
        output dst_valid,
        output dst_data
    );
endinterface

// File: rtl/cdc_sync_n.sv
// N-flop level synchroniser; every stage resets to 0 asynchronously.
module cdc_sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/cdc_bus_rx.sv
// Destination side of a 4-phase req/ack bus synchroniser with valid/ready output.
// Optional ACK-phase protocol timeout is built when CDC_BUS_RX_TIMEOUT_EN is defined.
module cdc_bus_rx
    import cdc_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    cdc_bus_rx_if.slave       bus,
    output logic              err_timeout
);
    generate
        if (SYNC_STAGES < CDC_SYNC_STAGES_MIN || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("cdc_bus_rx: illegal parameter value");
        end
    endgenerate

    state_t           state_reg;
    logic             ack_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             req_s;

    cdc_sync_n #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.src_req),
        .q     (req_s)
    );

    // src_data is only sampled on IDLE->PRESENT; the source keeps it
    // stable until it sees dst_ack, so a multi-bit capture is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_s) begin
                        data_reg  <= bus.src_data;
                        valid_reg <= 1'b1;
                        state_reg <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.dst_ready) begin
                        valid_reg <= 1'b0;
                        ack_reg   <= 1'b1;
                        state_reg <= ACK;
                    end
                end
                ACK: begin
                    // Leave only once the request has been withdrawn, so a
                    // long-held request is never captured twice.
                    if (!req_s) begin
                        ack_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    ack_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.dst_ack   = ack_reg;
    assign bus.dst_valid = valid_reg;
    assign bus.dst_data  = data_reg;

`ifdef CDC_BUS_RX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    // Counts ACK cycles with the request still high; the flag rises on the
    // edge the count reaches TIMEOUT_CYCLES and holds until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (state_reg == PRESENT && bus.dst_ready) begin
            cnt_reg <= '0;
        end else if (state_reg == ACK && req_s) begin
            if (cnt_reg != CNT_W'(TIMEOUT_CYCLES)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_timeout = err_reg;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_bus_rx.sv
// Randomised bench for cdc_bus_rx: drives 4-phase transfers and checks latency,
// hold behaviour, ordering, reset and the optional timeout against a simple model.
module tb_cdc_bus_rx;
    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 16;
`ifdef CDC_BUS_RX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic err_timeout;

    cdc_bus_rx_if #(.WIDTH(WIDTH)) bus ();

    cdc_bus_rx #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] sent_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 4-phase round trip as seen from the source and downstream.
    task automatic xfer(input logic [WIDTH-1:0] data, input int delay, input int hold, input bit scramble);
        int k;
        logic [WIDTH-1:0] a, b;
        bus.src_data = data;
        bus.src_req  = 1'b1;
        sent_q.push_back(data);
        for (int i = 1; i <= SYNC + 1; i++) begin
            tick();
            check("valid_latency", bus.dst_valid, (i == SYNC + 1));
            check("ack_before_accept", bus.dst_ack, 0);
        end
        check("capture", bus.dst_data, data);
        for (int i = 0; i < delay; i++) begin
            if (scramble) bus.src_data = WIDTH'($urandom);
            tick();
            check("hold_valid", bus.dst_valid, 1);
            check("hold_data", bus.dst_data, data);
            check("hold_no_ack", bus.dst_ack, 0);
        end
        bus.dst_ready = 1'b1;
        if (bus.dst_valid) got_q.push_back(bus.dst_data);
        tick();
        bus.dst_ready = 1'($urandom_range(0, 1));
        check("ack_after_accept", bus.dst_ack, 1);
        check("valid_drop", bus.dst_valid, 0);
        k = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            k++;
            if (TMO_EN && k >= TMO) exp_err = 1'b1;
            check("no_recapture", bus.dst_valid, 0);
            check("ack_held", bus.dst_ack, 1);
            check("err_timeout", err_timeout, exp_err);
        end
        bus.src_req  = 1'b0;
        bus.src_data = WIDTH'($urandom);
        for (int i = 1; i <= SYNC + 1; i++) begin
            tick();
            k++;
            if (TMO_EN && i <= SYNC && k >= TMO) exp_err = 1'b1;
            check("ack_fall_latency", bus.dst_ack, (i <= SYNC));
            check("valid_after_fall", bus.dst_valid, 0);
            check("err_timeout", err_timeout, exp_err);
        end
        bus.dst_ready = 1'b0;
        if (got_q.size() == 0 || sent_q.size() == 0) begin
            check("transfer_seen", got_q.size(), sent_q.size() + 1);
        end else begin
            a = got_q.pop_front();
            b = sent_q.pop_front();
            check("order", a, b);
        end
        $display("xfer data=%02h ready_delay=%0d req_hold=%0d err=%0b", data, delay, hold, err_timeout);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.src_req   = 1'b0;
        bus.src_data  = '0;
        bus.dst_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", bus.dst_valid, 0);
        check("rst_ack", bus.dst_ack, 0);
        check("rst_data", bus.dst_data, 0);
        check("rst_err", err_timeout, 0);
        rst_n = 1'b1;

        // dst_ready with nothing presented must be ignored.
        bus.dst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_valid", bus.dst_valid, 0);
            check("idle_ack", bus.dst_ack, 0);
        end
        bus.dst_ready = 1'b0;

        xfer(8'hA5, 0, 0, 1'b0);
        xfer(8'h3C, 20, 0, 1'b1);
        xfer(8'h01, 1, 1, 1'b0);
        xfer(8'h02, 0, 2, 1'b0);
        xfer(8'h03, 3, 0, 1'b0);
        for (int n = 0; n < 12; n++) begin
            xfer(WIDTH'($urandom), $urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Reset while a word is being presented.
        bus.src_data = 8'h77;
        bus.src_req  = 1'b1;
        for (int i = 0; i < SYNC + 1; i++) tick();
        check("pre_reset_valid", bus.dst_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.dst_valid, 0);
        check("async_rst_ack", bus.dst_ack, 0);
        check("async_rst_data", bus.dst_data, 0);
        tick();
        rst_n   = 1'b1;
        exp_err = 1'b0;
        xfer(8'h77, 2, 0, 1'b0);

        // Request held long after ack: no second capture, timeout when enabled.
        xfer(8'h5A, 1, 20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_sticky", err_timeout, exp_err);
            check("final_idle_valid", bus.dst_valid, 0);
        end
        check("sb_empty", got_q.size() + sent_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
